// File: rtl/reg_alu_pipe.sv
// Register file + single-cycle ALU behind a one-stage execute pipeline.
// Optional macro REG_ALU_PIPE_BYPASS_EN forwards the EX result on a read-after-write hazard instead of stalling.
module reg_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             sel,
  input  logic             wr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic             ex_valid_q, ex_valid_d;
  logic [2:0]       ex_op_q, ex_op_d;
  logic             ex_sel_q, ex_sel_d;
  logic             ex_wr_q, ex_wr_d;
  logic [AW-1:0]    ex_wr_addr_q, ex_wr_addr_d;
  logic [WIDTH-1:0] ex_din_q, ex_din_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] ex_result_s;
  logic             ex_cout_s;
  logic             ex_wb_s;
  logic             haz_a_s, haz_b_s;
  logic [WIDTH-1:0] rd_a_s, rd_b_s;
  logic [WIDTH-1:0] opa_s, opb_s;
  logic             in_ready_s;
  logic             accept_s;

  assign sum_s  = {1'b0, ex_a_q} + {1'b0, ex_b_q};
  assign diff_s = {1'b0, ex_a_q} - {1'b0, ex_b_q};

  // ALU result and carry/borrow for the instruction held in EX
  always_comb begin
    ex_result_s = {WIDTH{1'b0}};
    ex_cout_s   = 1'b0;
    if (ex_sel_q) begin
      case (ex_op_q)
        3'b000: begin ex_result_s = sum_s[WIDTH-1:0];  ex_cout_s = sum_s[WIDTH];  end
        3'b001: begin ex_result_s = diff_s[WIDTH-1:0]; ex_cout_s = diff_s[WIDTH]; end
        3'b010: ex_result_s = ex_a_q & ex_b_q;
        3'b011: ex_result_s = ex_a_q | ex_b_q;
        3'b100: ex_result_s = ex_a_q ^ ex_b_q;
        3'b101: ex_result_s = ~ex_a_q;
        3'b110: begin ex_result_s = {ex_a_q[WIDTH-2:0], 1'b0}; ex_cout_s = ex_a_q[WIDTH-1]; end
        3'b111: begin ex_result_s = {1'b0, ex_a_q[WIDTH-1:1]}; ex_cout_s = ex_a_q[0]; end
        default: begin ex_result_s = {WIDTH{1'b0}}; ex_cout_s = 1'b0; end
      endcase
    end else begin
      ex_result_s = ex_din_q;
      ex_cout_s   = 1'b0;
    end
  end

  // Hazard detection and operand selection; register 0 always reads as zero
  always_comb begin
    ex_wb_s = ex_valid_q & ex_wr_q & (ex_wr_addr_q != {AW{1'b0}});
    haz_a_s = ex_wb_s & (rd_addr_a == ex_wr_addr_q);
    haz_b_s = ex_wb_s & (rd_addr_b == ex_wr_addr_q);
    if (rd_addr_a == {AW{1'b0}}) begin
      rd_a_s = {WIDTH{1'b0}};
    end else begin
      rd_a_s = regs_q[rd_addr_a];
    end
    if (rd_addr_b == {AW{1'b0}}) begin
      rd_b_s = {WIDTH{1'b0}};
    end else begin
      rd_b_s = regs_q[rd_addr_b];
    end
`ifdef REG_ALU_PIPE_BYPASS_EN
    opa_s      = haz_a_s ? ex_result_s : rd_a_s;
    opb_s      = haz_b_s ? ex_result_s : rd_b_s;
    in_ready_s = 1'b1;
`else
    // Stall one cycle; the write-back lands at the same edge, so the next read sees it
    opa_s      = rd_a_s;
    opb_s      = rd_b_s;
    in_ready_s = ~(haz_a_s | haz_b_s);
`endif
  end

  // Next-state for EX, output registers and register-file write-back
  always_comb begin
    accept_s   = in_valid & in_ready_s;
    ex_valid_d = accept_s;
    if (accept_s) begin
      ex_op_d      = op;
      ex_sel_d     = sel;
      ex_wr_d      = wr;
      ex_wr_addr_d = wr_addr;
      ex_din_d     = d_in;
      ex_a_d       = opa_s;
      ex_b_d       = opb_s;
    end else begin
      ex_op_d      = ex_op_q;
      ex_sel_d     = ex_sel_q;
      ex_wr_d      = ex_wr_q;
      ex_wr_addr_d = ex_wr_addr_q;
      ex_din_d     = ex_din_q;
      ex_a_d       = ex_a_q;
      ex_b_d       = ex_b_q;
    end

    res_valid_d = ex_valid_q;
    if (ex_valid_q) begin
      res_d = ex_result_s;
      if (ex_sel_q) begin
        cout_d = ex_cout_s;
        zero_d = (ex_result_s == {WIDTH{1'b0}});
      end else begin
        cout_d = cout_q;
        zero_d = zero_q;
      end
    end else begin
      res_d  = res_q;
      cout_d = cout_q;
      zero_d = zero_q;
    end

    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (ex_wb_s && (ex_wr_addr_q == AW'(i))) ? ex_result_s : regs_q[i];
    end
  end

  // State registers; reset drops any in-flight EX instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      ex_valid_q   <= 1'b0;
      ex_op_q      <= 3'b000;
      ex_sel_q     <= 1'b0;
      ex_wr_q      <= 1'b0;
      ex_wr_addr_q <= {AW{1'b0}};
      ex_din_q     <= {WIDTH{1'b0}};
      ex_a_q       <= {WIDTH{1'b0}};
      ex_b_q       <= {WIDTH{1'b0}};
      res_valid_q  <= 1'b0;
      res_q        <= {WIDTH{1'b0}};
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_sel_q     <= ex_sel_d;
      ex_wr_q      <= ex_wr_d;
      ex_wr_addr_q <= ex_wr_addr_d;
      ex_din_q     <= ex_din_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      res_valid_q  <= res_valid_d;
      res_q        <= res_d;
      cout_q       <= cout_d;
      zero_q       <= zero_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule
